// File: rtl/fetch_unit.sv
// Instruction fetch: issues in-order imem requests, queues responses, drops stale ones after redirects.
// Optional FETCH_MISALIGN_CHECK_EN: flag and halt on misaligned redirect targets.
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fetch_misaligned
);

  localparam int QAW = $clog2(QUEUE_DEPTH);
  localparam int CW  = $clog2(QUEUE_DEPTH + 1);
  localparam int FAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0]  QD    = CW'(QUEUE_DEPTH);
  localparam logic [CW-1:0]  MO    = CW'(MAX_OUTSTANDING);
  localparam logic [FAW-1:0] FLAST = FAW'(MAX_OUTSTANDING - 1);

  logic [31:0]    fetch_pc;
  logic [CW-1:0]  q_count;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  drop_cnt;
  logic [QAW-1:0] q_head;
  logic [QAW-1:0] q_tail;
  logic [31:0]    q_pc    [QUEUE_DEPTH];
  logic [31:0]    q_instr [QUEUE_DEPTH];
  logic [31:0]    fl_pc   [MAX_OUTSTANDING];
  logic [FAW-1:0] fl_wr;
  logic [FAW-1:0] fl_rd;
  logic [31:0]    target_pc;
  logic           halted;
  logic           req_fire;
  logic           resp_keep;
  logic           pop;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target_pc = redirect_pc;

  // A misaligned target parks the fetcher until an aligned redirect arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      halted <= 1'b0;
    end else if (redirect_valid) begin
      halted <= (redirect_pc[1:0] != 2'b00);
    end
  end

  assign fetch_misaligned = halted && !reset;
`else
  assign target_pc        = redirect_pc & 32'hFFFF_FFFC;
  assign halted           = 1'b0;
  assign fetch_misaligned = 1'b0;
`endif

  always_comb begin
    imem_req_valid = !reset && !redirect_valid && !halted
                   && (({1'b0, q_count} + {1'b0, outstanding}) < {1'b0, QD})
                   && (outstanding < MO);
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    resp_keep      = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;
    if_valid       = !reset && (q_count != '0);
    pop            = if_valid && if_ready;
    if_pc          = if_valid ? q_pc[q_head]    : 32'h0;
    if_instr       = if_valid ? q_instr[q_head] : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      q_count     <= '0;
      q_head      <= '0;
      q_tail      <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      fl_wr       <= '0;
      fl_rd       <= '0;
    end else begin
      if (req_fire) begin
        fl_wr <= (fl_wr == FLAST) ? '0 : fl_wr + 1'b1;
      end
      if (imem_resp_valid) begin
        fl_rd <= (fl_rd == FLAST) ? '0 : fl_rd + 1'b1;
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);

      if (redirect_valid) begin
        // outstanding already counts pending drops, so every in-flight reply becomes stale
        fetch_pc <= target_pc;
        drop_cnt <= outstanding - CW'(imem_resp_valid);
        q_count  <= '0;
        q_head   <= '0;
        q_tail   <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        drop_cnt <= drop_cnt - CW'(imem_resp_valid && (drop_cnt != '0));
        if (resp_keep) begin
          q_tail <= q_tail + 1'b1;
        end
        if (pop) begin
          q_head <= q_head + 1'b1;
        end
        q_count <= q_count + CW'(resp_keep) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      fl_pc[fl_wr] <= fetch_pc;
    end
    if (resp_keep) begin
      q_pc[q_tail]    <= fl_pc[fl_rd];
      q_instr[q_tail] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized/directed bench for fetch_unit against a queue-based model of the fetch stream.
module tb_fetch_unit;

  localparam int          QD = 4;
  localparam int          MO = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fetch_misaligned;

  fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(QD), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .fetch_misaligned(fetch_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] iq[$];
  logic [31:0] model_pc;
  bit          model_halt;
  int          cyc;
  int          lat_min;
  int          lat_max;
  int          n_checks;
  int          n_fail;
  bit          prev_hold;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic do_reset(input int n);
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    imem_req_ready  = 1'b1;
    if_ready        = 1'b1;
    repeat (n) begin
      @(negedge clk);
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_if_pc", if_pc, 0);
      chk("rst_if_instr", if_instr, 0);
      chk("rst_misaligned", fetch_misaligned, 0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    mem_q.delete();
    iq.delete();
    model_pc   = RPC;
    model_halt = 1'b0;
    prev_hold  = 1'b0;
    cyc        = 0;
  endtask

  task automatic step(input bit rdy, input bit ifr, input bit redir, input logic [31:0] tgt);
    bit          resp;
    bit          exp_req;
    mreq_t       e;
    logic [31:0] head;
    int          lat;
    resp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_req_ready  = rdy;
    if_ready        = ifr;
    redirect_valid  = redir;
    redirect_pc     = tgt;
    imem_resp_valid = resp;
    imem_resp_data  = resp ? mem_fn(mem_q[0].addr) : 32'hDEAD_BEEF;
    @(negedge clk);

    chk("if_valid", if_valid, (iq.size() != 0));
    if (iq.size() != 0) begin
      head = iq[0];
      chk("if_pc", if_pc, head);
      chk("if_instr", if_instr, mem_fn(head));
    end
    if (prev_hold) begin
      chk("hold_pc", if_pc, prev_pc);
      chk("hold_instr", if_instr, prev_instr);
    end
    exp_req = !redir && !model_halt && (mem_q.size() < MO) && (iq.size() + mem_q.size() < QD);
    chk("req_valid", imem_req_valid, exp_req);
    if (exp_req) chk("req_addr", imem_req_addr, model_pc);
    chk("misaligned", fetch_misaligned, model_halt);

    prev_hold  = if_valid && !ifr && !redir;
    prev_pc    = if_pc;
    prev_instr = if_instr;
    if ((iq.size() != 0) && ifr && !redir) void'(iq.pop_front());
    if (resp) begin
      e = mem_q.pop_front();
      if (!redir && !e.stale) iq.push_back(e.addr);
    end
    if (redir) begin
      iq.delete();
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
      model_pc   = tgt;
      model_halt = (tgt[1:0] != 2'b00);
`else
      model_pc   = tgt & 32'hFFFF_FFFC;
`endif
    end else if (exp_req && rdy) begin
      lat = $urandom_range(lat_max, lat_min);
      mem_q.push_back('{model_pc, cyc + lat, 1'b0});
      model_pc = model_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    lat_min  = 1;
    lat_max  = 1;
    do_reset(2);

    // streaming with 1-cycle memory, then a decode stall and release
    repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_full_req_valid", imem_req_valid, 0);
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

    // 3-cycle memory: redirect while two requests are in flight
    lat_min = 3;
    lat_max = 3;
    do_reset(1);
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h100);
    repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0);

    // redirect coinciding with a response, then back-to-back redirects
    lat_min = 1;
    lat_max = 1;
    do_reset(1);
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h200);
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h300);
    step(1'b1, 1'b1, 1'b1, 32'h400);
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);

    // misaligned target, then aligned recovery
    step(1'b1, 1'b1, 1'b1, 32'h102);
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h104);
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);

    // address wrap at the top of the address space
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

    // random ready/stall/redirect with variable memory latency
    lat_min = 1;
    lat_max = 3;
    repeat (800) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 24) == 0), 32'($urandom));
    end
    repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
